// File: rtl/ultra_sonic_responder_if.sv
// Host-side write port of the ultrasonic responder: loads the echo length register.
// Handshake: write_valid qualifies write_data for exactly the cycles it is high; there is
// no ready, because the slave accepts every valid cycle in every state with no back-pressure.
interface ultra_sonic_responder_if #(
  parameter int COUNT_WIDTH = 32
);
  logic [COUNT_WIDTH-1:0] write_data;
  logic                   write_valid;

  modport master (
    output write_data,
    output write_valid
  );

  modport slave (
    input write_data,
    input write_valid
  );
endinterface

// File: rtl/ultra_sonic_responder.sv
// HC-SR04 style responder: qualifies a trigger pulse, waits the burst delay, then drives
// echo high for the host-programmed number of cycles, followed by a dead holdoff window.
module ultra_sonic_responder #(
  parameter int COUNT_WIDTH = 32,
  parameter int TRIG_MIN    = 500,
  parameter int BURST_DELAY = 10000,
  parameter int TIMEOUT     = 1900000,
  parameter int HOLDOFF     = 50000,
  parameter int DEFAULT_LEN = 5800
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trigger,
  ultra_sonic_responder_if.slave bus,
  output logic                   echo,
  output logic                   busy,
  output logic                   done,
  output logic                   runt,
  output logic [2:0]             state_o
);

  localparam int MAX_A   = (TRIG_MIN > BURST_DELAY) ? TRIG_MIN : BURST_DELAY;
  localparam int MAX_CNT = (MAX_A > HOLDOFF) ? MAX_A : HOLDOFF;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG_HIGH = 3'd1,
    S_BURST     = 3'd2,
    S_ECHO      = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, trig_s_q, trig_q;
  logic [CNT_W-1:0]       trig_cnt_q, trig_cnt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] ecnt_q, ecnt_d;
  logic [COUNT_WIDTH-1:0] len_q, len_d;
  logic [COUNT_WIDTH-1:0] act_len;
  logic                   echo_q, echo_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   runt_q, runt_d;

  // A zero length means "no object": the sensor reports its maximum echo instead.
  assign act_len = (len_q == '0) ? COUNT_WIDTH'(TIMEOUT) : len_q;

  always_comb begin
    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    cnt_d      = cnt_q;
    ecnt_d     = ecnt_q;
    echo_d     = echo_q;
    done_d     = 1'b0;
    runt_d     = 1'b0;
    len_d      = bus.write_valid ? bus.write_data : len_q;

    case (state_q)
      S_IDLE: begin
        if (trig_s_q && !trig_q) begin
          state_d    = S_TRIG_HIGH;
          trig_cnt_d = CNT_W'(1);
        end
      end
      S_TRIG_HIGH: begin
        if (trig_s_q) begin
          if (trig_cnt_q != '1) trig_cnt_d = trig_cnt_q + CNT_W'(1);
        end else if (trig_cnt_q >= CNT_W'(TRIG_MIN)) begin
          state_d = S_BURST;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
          runt_d  = 1'b1;
        end
      end
      S_BURST: begin
        if (cnt_q == CNT_W'(BURST_DELAY - 1)) begin
          state_d = S_ECHO;
          echo_d  = 1'b1;
          ecnt_d  = act_len;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ECHO: begin
        if (ecnt_q == COUNT_WIDTH'(1)) begin
          state_d = S_HOLDOFF;
          echo_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          ecnt_d = ecnt_q - COUNT_WIDTH'(1);
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      trig_s_q   <= 1'b0;
      trig_q     <= 1'b0;
      state_q    <= S_IDLE;
      trig_cnt_q <= '0;
      cnt_q      <= '0;
      ecnt_q     <= '0;
      len_q      <= COUNT_WIDTH'(DEFAULT_LEN);
      echo_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      runt_q     <= 1'b0;
    end else begin
      sync1_q    <= trigger;
      trig_s_q   <= sync1_q;
      trig_q     <= trig_s_q;
      state_q    <= state_d;
      trig_cnt_q <= trig_cnt_d;
      cnt_q      <= cnt_d;
      ecnt_q     <= ecnt_d;
      len_q      <= len_d;
      echo_q     <= echo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      runt_q     <= runt_d;
    end
  end

  assign echo    = echo_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign runt    = runt_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_ultra_sonic_responder.sv
// Directed and randomized checks of the ultrasonic responder against a measurement-level
// model: each accepted trigger yields one echo of the programmed (or timeout) length.
module tb_ultra_sonic_responder;
  localparam int CW          = 32;
  localparam int TRIG_MIN    = 10;
  localparam int BURST_DELAY = 20;
  localparam int TIMEOUT     = 1000;
  localparam int HOLDOFF     = 50;
  localparam int DEFAULT_LEN = 40;
  // Ticks from driving trigger low until the first sample with echo high:
  // one tick reaches the first low-sampling edge, then BURST_DELAY+2 more edges.
  localparam int LAT         = BURST_DELAY + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       trigger;
  logic       echo, busy, done, runt;
  logic [2:0] state_o;

  ultra_sonic_responder_if #(.COUNT_WIDTH(CW)) bus ();

  ultra_sonic_responder #(
    .COUNT_WIDTH(CW), .TRIG_MIN(TRIG_MIN), .BURST_DELAY(BURST_DELAY),
    .TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF), .DEFAULT_LEN(DEFAULT_LEN)
  ) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .bus(bus.slave),
    .echo(echo), .busy(busy), .done(done), .runt(runt), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          len_model;
  logic [CW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int act_model();
    return (len_model == 0) ? TIMEOUT : len_model;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_len(input int v);
    bus.write_data  = CW'(v);
    bus.write_valid = 1'b1;
    tick();
    bus.write_valid = 1'b0;
    len_model = v;
  endtask

  task automatic pulse_trig(input int n);
    trigger = 1'b1;
    repeat (n) tick();
    trigger = 1'b0;
  endtask

  // Called right after trigger is driven low. mode 1 toggles trigger during echo and
  // holdoff; mode 2 raises trigger during holdoff and leaves it high.
  task automatic measure(input string tag, input int wr_rise_at, input int wr_echo_at,
                         input int wr_val, input int mode);
    int k, w, extra;
    logic [CW-1:0] exp_w;
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    k = 0;
    while (echo !== 1'b1 && k < 200) begin
      if (k == wr_rise_at) begin
        bus.write_data  = CW'(wr_val);
        bus.write_valid = 1'b1;
      end
      tick();
      bus.write_valid = 1'b0;
      k++;
    end
    check({tag, " latency"}, k, LAT);
    w = 0;
    while (echo === 1'b1 && w < 2000) begin
      if (w == wr_echo_at) begin
        bus.write_data  = CW'(wr_val);
        bus.write_valid = 1'b1;
      end
      if (mode == 1) trigger = (w >= 10 && w < 40);
      w++;
      tick();
      bus.write_valid = 1'b0;
    end
    trigger = (mode == 2) ? trigger : 1'b0;
    check({tag, " width"}, w, exp_w);
    check({tag, " done at fall"}, done, 1'b1);
    extra = 0;
    for (int i = 0; i < HOLDOFF - 1; i++) begin
      if (mode == 1) trigger = (i >= 5 && i < 25);
      if (mode == 2) trigger = trigger | (i >= 10);
      tick();
      extra += int'(done) + int'(echo);
    end
    if (mode == 1) trigger = 1'b0;
    check({tag, " holdoff quiet"}, extra, 0);
    check({tag, " busy in holdoff"}, busy, 1'b1);
    tick();
    check({tag, " idle after holdoff"}, busy, 1'b0);
  endtask

  task automatic expect_runt(input string tag);
    int rc, ec;
    rc = 0;
    ec = 0;
    repeat (8) begin
      tick();
      rc += int'(runt);
      ec += int'(echo);
    end
    check({tag, " runt pulses"}, rc, 1);
    check({tag, " no echo"}, ec, 0);
    check({tag, " back idle"}, busy, 1'b0);
  endtask

  task automatic trig_and_expect(input string tag, input int n);
    if (n >= TRIG_MIN) begin
      exp_q.push_back(CW'(act_model()));
      pulse_trig(n);
      check({tag, " busy after trigger"}, busy, 1'b1);
      measure(tag, -1, -1, 0, 0);
    end else begin
      pulse_trig(n);
      expect_runt(tag);
    end
  endtask

  task automatic quiet_window(input string tag, input int n);
    int ec;
    ec = 0;
    repeat (n) begin
      tick();
      ec += int'(echo);
    end
    check({tag, " no echo"}, ec, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, ec, n, v;
    reset           = 1'b1;
    trigger         = 1'b0;
    bus.write_data  = '0;
    bus.write_valid = 1'b0;
    len_model       = DEFAULT_LEN;
    repeat (3) tick();
    check("reset echo", echo, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset runt", runt, 1'b0);
    reset = 1'b0;
    repeat (2) tick();

    trig_and_expect("t1 default", 12);

    write_len(300);
    trig_and_expect("t2 len300", 12);
    write_len(0);
    trig_and_expect("t2 timeout", 12);

    write_len(25);
    trig_and_expect("t3 runt9", TRIG_MIN - 1);
    trig_and_expect("t3 min10", TRIG_MIN);

    // Trigger activity during echo and holdoff must not produce a second echo.
    write_len(300);
    exp_q.push_back(CW'(act_model()));
    pulse_trig(12);
    measure("t4 pulses", -1, -1, 0, 1);
    quiet_window("t4 after pulses", 100);
    check("t4 idle", busy, 1'b0);

    // Trigger held high across the end of holdoff: no new measurement without a fresh edge.
    write_len(30);
    exp_q.push_back(CW'(act_model()));
    pulse_trig(12);
    measure("t4 held", -1, -1, 0, 2);
    quiet_window("t4 held high", 80);
    check("t4 held idle", busy, 1'b0);
    trigger = 1'b0;
    quiet_window("t4 released", 40);
    trig_and_expect("t4 fresh edge", 12);

    // Stuck-high trigger saturates its count, then fires once released.
    trigger = 1'b1;
    ec = 0;
    repeat (130) begin
      tick();
      ec += int'(echo);
    end
    check("stuck no echo", ec, 0);
    check("stuck busy", busy, 1'b1);
    trigger = 1'b0;
    exp_q.push_back(CW'(act_model()));
    measure("stuck release", -1, -1, 0, 0);

    // Write mid-echo affects only the next measurement.
    write_len(300);
    exp_q.push_back(CW'(act_model()));
    pulse_trig(12);
    measure("t5 mid write", -1, 50, 77, 0);
    len_model = 77;
    trig_and_expect("t5 next77", 12);

    // Write on the latch edge: old value wins.
    exp_q.push_back(CW'(act_model()));
    pulse_trig(12);
    measure("t5 latch write", BURST_DELAY + 2, -1, 150, 0);
    len_model = 150;
    trig_and_expect("t5 next150", 12);

    // Randomized lengths and trigger widths around the qualification threshold.
    for (int i = 0; i < 8; i++) begin
      v = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 150));
      write_len(v);
      n = int'($urandom_range(TRIG_MIN - 3, TRIG_MIN + 6));
      trig_and_expect($sformatf("rand%0d n%0d len%0d", i, n, v), n);
    end

    // Asynchronous reset in the middle of an echo.
    write_len(300);
    pulse_trig(12);
    k = 0;
    while (echo !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    check("t6 echo started", echo, 1'b1);
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    check("t6 async echo drop", echo, 1'b0);
    check("t6 async busy drop", busy, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    len_model = DEFAULT_LEN;
    quiet_window("t6 after reset", 40);
    trig_and_expect("t6 clean echo", 12);

    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
